// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI sample transmitter.
package spi_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOADED,
        SHIFT,
        DONE
    } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with single-cycle rise/fall pulses.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~prev;
    assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_sample_tx.sv
// SPI slave (mode 0) that streams the latest datapath sample to the MCU, MSB first.
// Define SPI_RX_EN to also capture the MCU's sdi word into rx_word/rx_valid.
//
// state  | meaning
// IDLE   | no sample loaded, waiting for tfr_ready or cs_n fall
// LOADED | sample held in shift register, waiting for cs_n fall
// SHIFT  | frame in progress, sdo driven from shift register MSB
// DONE   | all bits sent, waiting for cs_n rise
module spi_sample_tx
    import spi_pkg::*;
#(
    parameter int WIDTH       = SAMPLE_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sck,
    input  logic             cs_n,
    input  logic             sdi,
    output logic             sdo,
    input  logic             tfr_ready,
    input  logic [WIDTH-1:0] sample_in,
    output logic             transmit,
    output logic             frame_done,
    output logic             underrun,
    output logic [WIDTH-1:0] rx_word,
    output logic             rx_valid
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    spi_state_e       state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bitcnt;
    logic             sck_rise, sck_fall, cs_rise, cs_fall;
    logic             frame_start, shift_rise, last_rise;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk   (clk),
        .reset (reset),
        .d     (sck),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .reset (reset),
        .d     (cs_n),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // An abort (cs_n rise) always wins over a coincident sck edge.
    assign frame_start = cs_fall && (state == IDLE || state == LOADED);
    assign shift_rise  = (state == SHIFT) && !cs_rise && sck_rise;
    assign last_rise   = shift_rise && (bitcnt == LAST_BIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            sdo        <= 1'b0;
            transmit   <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                IDLE, LOADED: begin
                    if (cs_fall) begin
                        state    <= SHIFT;
                        transmit <= 1'b1;
                        bitcnt   <= '0;
                        if (tfr_ready) begin
                            shreg <= sample_in;
                            sdo   <= sample_in[WIDTH-1];
                        end else if (state == LOADED) begin
                            sdo <= shreg[WIDTH-1];
                        end else begin
                            shreg    <= '0;
                            sdo      <= 1'b0;
                            underrun <= 1'b1;
                        end
                    end else if (tfr_ready) begin
                        shreg <= sample_in;
                        state <= LOADED;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state    <= IDLE;
                        transmit <= 1'b0;
                        shreg    <= '0;
                        sdo      <= 1'b0;
                        bitcnt   <= '0;
                    end else if (sck_rise) begin
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == LAST_BIT) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            shreg      <= '0;
                            sdo        <= 1'b0;
                        end
                    end else if (sck_fall) begin
                        shreg <= shreg << 1;
                        sdo   <= shreg[WIDTH-2];
                    end
                end
                DONE: begin
                    if (cs_rise) begin
                        state    <= IDLE;
                        transmit <= 1'b0;
                        bitcnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_RX_EN
    logic [SYNC_STAGES-1:0] sdi_chain;
    logic [WIDTH-1:0]       rx_shreg;
    logic                   sdi_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sdi_chain <= '0;
        end else begin
            sdi_chain[0] <= sdi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sdi_chain[i] <= sdi_chain[i-1];
            end
        end
    end

    assign sdi_s = sdi_chain[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_shreg <= '0;
            rx_word  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (frame_start) begin
                rx_shreg <= '0;
            end else if (shift_rise) begin
                rx_shreg <= {rx_shreg[WIDTH-2:0], sdi_s};
                if (last_rise) begin
                    rx_word  <= {rx_shreg[WIDTH-2:0], sdi_s};
                    rx_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_rx;
    assign unused_rx = sdi ^ frame_start ^ last_rise;
    assign rx_word   = '0;
    assign rx_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_sample_tx.sv
// Self-checking bench for spi_sample_tx: an MCU-side SPI master plus a sample-level reference model.
module tb_spi_sample_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        sck, cs_n, sdi, sdo;
    logic        tfr_ready;
    logic [15:0] sample_in;
    logic        transmit, frame_done, underrun, rx_valid;
    logic [15:0] rx_word;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0, ur_cnt = 0, rv_bad = 0;

    bit          m_loaded = 0;
    logic [15:0] m_sample = '0;

    spi_sample_tx #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .sck        (sck),
        .cs_n       (cs_n),
        .sdi        (sdi),
        .sdo        (sdo),
        .tfr_ready  (tfr_ready),
        .sample_in  (sample_in),
        .transmit   (transmit),
        .frame_done (frame_done),
        .underrun   (underrun),
        .rx_word    (rx_word),
        .rx_valid   (rx_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (underrun === 1'b1) ur_cnt++;
`ifdef SPI_RX_EN
        if (rx_valid !== frame_done) rv_bad++;
`else
        if (rx_valid !== 1'b0) rv_bad++;
`endif
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_sample(input logic [15:0] v);
        @(negedge clk);
        tfr_ready = 1'b1;
        sample_in = v;
        @(negedge clk);
        tfr_ready = 1'b0;
        m_loaded  = 1;
        m_sample  = v;
        repeat (2) @(negedge clk);
    endtask

    // MCU master: cs_n low, nbits mode-0 sck cycles, cs_n left low.
    task automatic mcu_frame(input int nbits, input logic [15:0] mosi,
                             input bit pre_tfr, input logic [15:0] pre_val,
                             input bit mid_tfr, input logic [15:0] mid_val,
                             output logic [15:0] miso);
        miso = '0;
        @(negedge clk);
        cs_n = 1'b0;
        if (pre_tfr) begin
            tfr_ready = 1'b1;
            sample_in = pre_val;
        end
        repeat (4) @(negedge clk);
        tfr_ready = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sdi = mosi[15-i];
            repeat (8) @(negedge clk);
            miso = {miso[14:0], sdo};
            sck = 1'b1;
            repeat (8) @(negedge clk);
            sck = 1'b0;
            if (mid_tfr && i == 4) begin
                tfr_ready = 1'b1;
                sample_in = mid_val;
                @(negedge clk);
                tfr_ready = 1'b0;
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic end_frame(output bit tx_fell);
        @(negedge clk);
        cs_n    = 1'b1;
        sdi     = 1'b0;
        tx_fell = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (transmit === 1'b0) begin
                tx_fell = 1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0; sck = 1'b0; cs_n = 1'b1; sdi = 1'b0;
        tfr_ready = 1'b0; sample_in = '0;
        repeat (3) @(negedge clk);
        total++; if (sdo !== 1'b0)        begin bad++; $display("FAIL reset_sdo got=%b want=0", sdo); end
        total++; if (transmit !== 1'b0)   begin bad++; $display("FAIL reset_transmit got=%b want=0", transmit); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        total++; if (underrun !== 1'b0)   begin bad++; $display("FAIL reset_underrun got=%b want=0", underrun); end
        total++; if (rx_word !== 16'h0)   begin bad++; $display("FAIL reset_rx_word got=%h want=0000", rx_word); end
        total++; if (rx_valid !== 1'b0)   begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Full 16-bit frame checked against the model; returns nothing, checks inline.
    task automatic full_frame(input string name, input logic [15:0] mosi,
                              input bit pre_tfr, input logic [15:0] pre_val,
                              input bit mid_tfr, input logic [15:0] mid_val);
        logic [15:0] miso, exp;
        int fd0, ur0, exp_ur;
        bit tx_fell, tx_mid;
        if (pre_tfr) begin
            m_loaded = 1;
            m_sample = pre_val;
        end
        exp    = m_loaded ? m_sample : 16'h0;
        exp_ur = m_loaded ? 0 : 1;
        m_loaded = 0;
        fd0 = fd_cnt; ur0 = ur_cnt;
        mcu_frame(16, mosi, pre_tfr, pre_val, mid_tfr, mid_val, miso);
        tx_mid = (transmit === 1'b1);
        end_frame(tx_fell);
        total++; if (miso !== exp) begin bad++; $display("FAIL %s_sdo got=%h want=%h", name, miso, exp); end
        total++; if (fd_cnt - fd0 != 1) begin bad++; $display("FAIL %s_frame_done got=%0d want=1", name, fd_cnt - fd0); end
        total++; if (ur_cnt - ur0 != exp_ur) begin bad++; $display("FAIL %s_underrun got=%0d want=%0d", name, ur_cnt - ur0, exp_ur); end
        total++; if (!tx_mid) begin bad++; $display("FAIL %s_transmit_in_frame got=%b want=1", name, tx_mid); end
        total++; if (!tx_fell) begin bad++; $display("FAIL %s_transmit_fall got=%b want=1", name, tx_fell); end
`ifdef SPI_RX_EN
        total++; if (rx_word !== mosi) begin bad++; $display("FAIL %s_rx_word got=%h want=%h", name, rx_word, mosi); end
`else
        total++; if (rx_word !== 16'h0) begin bad++; $display("FAIL %s_rx_word got=%h want=0000", name, rx_word); end
`endif
    endtask

    task automatic test_normal;
        load_sample(16'hA5C3);
        full_frame("normal", 16'h3C5A, 0, '0, 0, '0);
    endtask

    task automatic test_underrun;
        full_frame("underrun", 16'hFFFF, 0, '0, 0, '0);
    endtask

    task automatic test_overwrite;
        load_sample(16'h1234);
        load_sample(16'hBEEF);
        full_frame("overwrite", 16'h0000, 0, '0, 0, '0);
    endtask

    task automatic test_coincident;
        load_sample(16'h1111);
        full_frame("coincident", 16'h5555, 1, 16'h2222, 0, '0);
    endtask

    task automatic test_ignore_tfr;
        load_sample(16'h5A5A);
        full_frame("mid_tfr", 16'hAAAA, 0, '0, 1, 16'h7777);
        full_frame("after_mid_tfr", 16'h0F0F, 0, '0, 0, '0);
    endtask

    task automatic test_abort;
        logic [15:0] miso, v;
        int fd0, ur0;
        bit tx_fell;
        v = 16'($urandom);
        load_sample(v);
        m_loaded = 0;
        fd0 = fd_cnt; ur0 = ur_cnt;
        mcu_frame(7, 16'hFFFF, 0, '0, 0, '0, miso);
        end_frame(tx_fell);
        total++; if (miso[6:0] !== v[15:9]) begin bad++; $display("FAIL abort_partial_sdo got=%h want=%h", miso[6:0], v[15:9]); end
        total++; if (fd_cnt != fd0) begin bad++; $display("FAIL abort_frame_done got=%0d want=0", fd_cnt - fd0); end
        total++; if (ur_cnt != ur0) begin bad++; $display("FAIL abort_underrun got=%0d want=0", ur_cnt - ur0); end
        total++; if (!tx_fell) begin bad++; $display("FAIL abort_transmit got=%b want=0", transmit); end
        load_sample(16'h0F0F);
        full_frame("after_abort", 16'h1357, 0, '0, 0, '0);
    endtask

    task automatic test_rx;
        load_sample(16'($urandom));
        full_frame("rx", 16'h8001, 0, '0, 0, '0);
        total++; if (rv_bad != 0) begin bad++; $display("FAIL rx_valid_align got=%0d want=0", rv_bad); end
    endtask

    task automatic test_mid_reset;
        logic [15:0] miso;
        load_sample(16'hC3A5);
        mcu_frame(9, 16'hFFFF, 0, '0, 0, '0, miso);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (sdo !== 1'b0)        begin bad++; $display("FAIL midrst_sdo got=%b want=0", sdo); end
        total++; if (transmit !== 1'b0)   begin bad++; $display("FAIL midrst_transmit got=%b want=0", transmit); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL midrst_frame_done got=%b want=0", frame_done); end
        total++; if (underrun !== 1'b0)   begin bad++; $display("FAIL midrst_underrun got=%b want=0", underrun); end
        total++; if (rx_word !== 16'h0)   begin bad++; $display("FAIL midrst_rx_word got=%h want=0000", rx_word); end
        total++; if (rx_valid !== 1'b0)   begin bad++; $display("FAIL midrst_rx_valid got=%b want=0", rx_valid); end
        cs_n = 1'b1; sck = 1'b0; sdi = 1'b0;
        m_loaded = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        load_sample(16'h3C5A);
        full_frame("after_reset", 16'hC001, 0, '0, 0, '0);
    endtask

    task automatic test_random;
        int n;
        for (int it = 0; it < 8; it++) begin
            n = int'($urandom_range(0, 2));
            for (int k = 0; k < n; k++) load_sample(16'($urandom));
            full_frame("random", 16'($urandom), 0, '0, 0, '0);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_underrun();
        test_overwrite();
        test_coincident();
        test_ignore_tfr();
        test_abort();
        test_rx();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_sample_tx.md
SPI_SAMPLE_TX -- requirements
Module: spi_sample_tx

Interface
REQ-001 Parameter: WIDTH, default 16, frame and sample width in bits.
REQ-002 Parameter: SYNC_STAGES, default 2, synchronizer depth on sck, cs_n and sdi.
REQ-003 Port: clk  input  1  system clock; the only clock in the block.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: sck  input  1  SPI clock from the MCU (MCU is master), mode 0.
REQ-006 Port: cs_n  input  1  MCU chip select, active-low.
REQ-007 Port: sdi  input  1  MCU-to-FPGA serial data.
REQ-008 Port: sdo  output  1  FPGA-to-MCU serial data, MSB first.
REQ-009 Port: tfr_ready  input  1  datapath sample-valid strobe/level.
REQ-010 Port: sample_in  input  WIDTH  processed audio sample.
REQ-011 Port: transmit  output  1  high while a frame is in progress; feeds the datapath FSM.
REQ-012 Port: frame_done  output  1  one-cycle pulse when a full frame completes.
REQ-013 Port: underrun  output  1  one-cycle pulse when a frame starts with no loaded sample.
REQ-014 Port: rx_word  output  WIDTH  last word received from the MCU.
REQ-015 Port: rx_valid  output  1  one-cycle pulse when rx_word updates.

Function
REQ-016 sck, cs_n and sdi SHALL pass through SYNC_STAGES flops; edges are detected on the synchronized values only.
REQ-017 clk SHALL be at least 8x the sck frequency; behaviour below this ratio is undefined.
REQ-018 The FSM SHALL have states IDLE, LOADED, SHIFT and DONE.
REQ-019 IDLE: tfr_ready high loads sample_in into the shift register; the FSM goes to LOADED.
REQ-020 IDLE: a synchronized cs_n fall loads all-zeros; underrun pulses; the FSM goes to SHIFT.
REQ-021 LOADED: tfr_ready high overwrites the shift register with the newest sample_in.
REQ-022 LOADED: a synchronized cs_n fall goes to SHIFT.
REQ-023 tfr_ready coincident with a cs_n fall in LOADED SHALL load the new sample before the first bit drives.
REQ-024 SHIFT: sdo SHALL present shift-register MSB from the first cycle of SHIFT.
REQ-025 SHIFT: on each synchronized sck rising edge, sdi is sampled and the bit counter increments.
REQ-026 SHIFT: on each synchronized sck falling edge, the shift register shifts left by one.
REQ-027 SHIFT: after WIDTH rising edges the FSM SHALL go to DONE, with frame_done pulsing on entry.
REQ-028 DONE: a synchronized cs_n rise goes to IDLE; extra sck edges in DONE are ignored and sdo is 0.
REQ-029 A cs_n rise in SHIFT before WIDTH bits SHALL abort to IDLE: no frame_done, no rx_valid, sample discarded.
REQ-030 tfr_ready in SHIFT or DONE SHALL be ignored.
REQ-031 transmit SHALL be high exactly in SHIFT and DONE.
REQ-032 sdo SHALL be 0 in IDLE and LOADED.
REQ-033 The bit counter SHALL be $clog2(WIDTH+1) bits wide and clear on every entry to SHIFT.

Reset
REQ-034 Asserting reset (low) SHALL immediately force: state IDLE, shift register 0, counter 0, sdo 0, transmit 0, frame_done 0, underrun 0, rx_word 0, rx_valid 0.
REQ-035 Synchronizer flops SHALL reset to the idle bus levels: sck 0, cs_n 1, sdi 0.
REQ-036 A reset mid-frame SHALL drop the frame; after release, the first cs_n fall is treated as a new frame.

Configuration
REQ-037 Macro SPI_RX_EN SHALL control the receive path.
REQ-038 With SPI_RX_EN defined: sdi bits shift into an RX register; at frame_done, rx_word takes the RX register and rx_valid pulses in the same cycle.
REQ-039 Without SPI_RX_EN: sdi is unused, rx_word is tied to 0 and rx_valid to 0, and no RX register is synthesized.

Structure
REQ-040 Shared package spi_pkg SHALL hold the FSM state enum type and localparam SAMPLE_W = 16.
REQ-041 One sub-module, sync_edge, SHALL provide a SYNC_STAGES synchronizer with rise/fall pulse outputs; it is instantiated for sck and cs_n.

Verification
REQ-042 Normal frame: tfr_ready pulse with sample_in=16'hA5C3, then cs_n low, 16 sck cycles -> sdo bits 1010_0101_1100_0011; frame_done pulses once; transmit falls after cs_n rises.
REQ-043 Underrun: cs_n falls in IDLE, 16 sck cycles -> sdo all 0; underrun pulses once; frame_done pulses.
REQ-044 Overwrite: tfr_ready with 16'h1234, then with 16'hBEEF before cs_n falls -> the MCU captures 16'hBEEF.
REQ-045 Abort: cs_n rises after 7 sck cycles -> state IDLE, no frame_done, transmit 0; the next loaded 16'h0F0F transfers intact.
REQ-046 RX (SPI_RX_EN): MCU drives 16'h8001 on sdi during the frame -> rx_word=16'h8001, with rx_valid coincident with frame_done.
REQ-047 Reset: reset is asserted low after 9 bits -> all outputs 0 immediately; a frame after release transfers correctly.
